scramble_sequencer: RTL and testbench
=====================================

SCRAMBLE_SEQUENCER -- requirements
Module: scramble_sequencer

Interface
REQ-001 Parameter NUM_MOVES, default 16, number of random flips per scramble (1..255).
REQ-002 Parameter GAP_CYCLES, default 15, idle cycles between consecutive scramble fires (1..255).
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-005 start  in  1  debounced scramble request, level; a 0->1 edge starts a scramble.
REQ-006 abort  in  1  level; high terminates an active scramble.
REQ-007 rand  in  3  free-running random bits; [2] = row/col select, [1:0] = index.
REQ-008 user_fire  in  1  debounced user fire.
REQ-009 user_row_column  in  4  one-hot user selection.
REQ-010 user_nrow  in  1  user row/column select (0 = row).
REQ-011 user_error  in  1  user selection invalid.
REQ-012 fire  out  1  fire strobe to grid cells.
REQ-013 row_column  out  4  one-hot selection to grid.
REQ-014 x_nrow  out  1  row/column select to grid.
REQ-015 busy  out  1  high while a scramble is in progress.
REQ-016 done  out  1  one-cycle pulse on scramble completion.
REQ-017 moves  out  8  scramble fires issued in the current or last scramble.

Function
REQ-018 FSM states: IDLE, PICK, FIRE, GAP, DONE.
REQ-019 IDLE: fire = user_fire & ~user_error, row_column = user_row_column, x_nrow = user_nrow (combinational pass-through); busy = 0.
REQ-020 IDLE -> PICK on a start 0->1 edge (edge register internal); moves cleared to 0 in the same cycle.
REQ-021 PICK (1 cycle): register move = {rand[2], one-hot(rand[1:0])}; -> FIRE.
REQ-022 FIRE (1 cycle): fire = 1, row_column/x_nrow driven from the move register; moves increments by 1; -> GAP.
REQ-023 GAP: fire = 0, move outputs held; lasts exactly GAP_CYCLES cycles; then -> DONE if moves == NUM_MOVES, else -> PICK.
REQ-024 DONE (1 cycle): done = 1, busy = 0; -> IDLE. Fire period is GAP_CYCLES + 2 cycles.
REQ-025 busy = 1 in PICK, FIRE and GAP; user inputs are ignored while busy.
REQ-026 A start edge while not in IDLE is ignored; start held high after DONE does not retrigger.
REQ-027 abort high in PICK, FIRE or GAP -> IDLE next cycle; no done pulse; moves keeps its value. If abort coincides with FIRE, that fire is still issued.
REQ-028 row_column is never multi-hot outside IDLE; in IDLE, user_error forces fire = 0.
REQ-029 The moves counter saturates at NUM_MOVES and never wraps.

Reset
REQ-030 reset = 0 -> IDLE, moves = 0, move register = 0, done = 0, edge register = 0, GAP counter = 0; this takes priority over all other inputs, including mid-scramble.
REQ-031 Outputs during reset follow the IDLE pass-through (REQ-019).

Configuration
REQ-032 Macro SCRAMBLE_NOREPEAT_EN defined: PICK rejects a move equal to the previous scramble move, stays in PICK and resamples rand on the next cycle; the first move of each scramble is always accepted.
REQ-033 Macro absent: PICK always accepts in one cycle; immediate repeats are allowed.

Structure
REQ-034 The shared package grid_pkg holds the FSM state enum, the move struct {nrow, row_column[3:0]}, GRID_DIM = 4, and a one-hot decode function.
REQ-035 One sub-module, gap_timer (load/count/expire), implements the GAP countdown; all other logic is flat.

Verification
REQ-036 IDLE pass-through: user_row_column = 0100, user_nrow = 1, user_fire = 1, user_error = 0 -> fire = 1, row_column = 0100, x_nrow = 1 in the same cycle; user_error = 1 -> fire = 0.
REQ-037 Full scramble with NUM_MOVES = 4, GAP_CYCLES = 3: start edge -> exactly 4 one-cycle fires spaced 5 cycles apart; done pulses once; moves = 4; busy falls in DONE.
REQ-038 Abort during the 2nd GAP -> IDLE next cycle, no done, moves = 2; user_fire passes through immediately afterwards.
REQ-039 Reset low during the 3rd FIRE -> next cycle IDLE, moves = 0, no further fires.
REQ-040 Retrigger: start held high through DONE -> no second scramble; start pulsed while busy -> ignored.
REQ-041 SCRAMBLE_NOREPEAT_EN, rand forced to 3'b101 for 3 cycles then 3'b010 -> 2nd PICK lasts 4 cycles; the 2nd move is x_nrow = 0, row_column = 0100.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types for the scramble sequencer: FSM state enum, grid move struct
// and the one-hot index decoder.
package grid_pkg;

    localparam int GRID_DIM = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_FIRE,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic                nrow;
        logic [GRID_DIM-1:0] row_column;
    } move_t;

    function automatic logic [GRID_DIM-1:0] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Countdown for the idle gap between scramble fires: load arms it, count
// steps it, expire marks the final gap cycle.
module gap_timer #(
    parameter int GAP_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'(GAP_CYCLES - 1);
        end else if (count && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expire = count && (cnt == 8'd0);

endmodule

// File: rtl/scramble_sequencer.sv
// Drives NUM_MOVES random row/column fires into the grid on a start edge and
// passes user fires through when idle. Optional macro: SCRAMBLE_NOREPEAT_EN.
module scramble_sequencer
    import grid_pkg::*;
#(
    parameter int NUM_MOVES  = 16,
    parameter int GAP_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [2:0]          rand_bits,
    input  logic                user_fire,
    input  logic [GRID_DIM-1:0] user_row_column,
    input  logic                user_nrow,
    input  logic                user_error,
    output logic                fire,
    output logic [GRID_DIM-1:0] row_column,
    output logic                x_nrow,
    output logic                busy,
    output logic                done,
    output logic [7:0]          moves,
    output state_t              fsm_state
);

    state_t     state, next_state, out_state;
    logic       start_q;
    logic       start_edge;
    logic       accept;
    logic       gap_expire;
    logic       last_move;
    move_t      move_reg;
    move_t      cand;
    logic [7:0] moves_reg;

    assign start_edge = start & ~start_q;
    assign cand       = {rand_bits[2], onehot(rand_bits[1:0])};
    assign last_move  = (moves_reg == 8'(NUM_MOVES));

`ifdef SCRAMBLE_NOREPEAT_EN
    // moves is still zero during the first PICK, so the first move always lands
    assign accept = (moves_reg == 8'd0) || (cand != move_reg);
`else
    assign accept = 1'b1;
`endif

    gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ST_FIRE),
        .count  (state == ST_GAP),
        .expire (gap_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            move_reg  <= '0;
            moves_reg <= 8'd0;
        end else begin
            state   <= next_state;
            start_q <= start;
            if (state == ST_IDLE && start_edge) begin
                moves_reg <= 8'd0;
            end
            if (state == ST_PICK && accept) begin
                move_reg <= cand;
            end
            if (state == ST_FIRE && !last_move) begin
                moves_reg <= moves_reg + 8'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_edge) next_state = ST_PICK;
            ST_PICK: begin
                if (abort)       next_state = ST_IDLE;
                else if (accept) next_state = ST_FIRE;
            end
            ST_FIRE: next_state = abort ? ST_IDLE : ST_GAP;
            ST_GAP: begin
                if (abort)           next_state = ST_IDLE;
                else if (gap_expire) next_state = last_move ? ST_DONE : ST_PICK;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // While reset is held the outputs behave as IDLE even if the register
    // still holds a mid-scramble state.
    assign out_state = reset ? state : ST_IDLE;

    always_comb begin
        fire       = 1'b0;
        row_column = move_reg.row_column;
        x_nrow     = move_reg.nrow;
        busy       = 1'b0;
        done       = 1'b0;
        case (out_state)
            ST_IDLE: begin
                fire       = user_fire & ~user_error;
                row_column = user_row_column;
                x_nrow     = user_nrow;
            end
            ST_PICK, ST_GAP: busy = 1'b1;
            ST_FIRE: begin
                busy = 1'b1;
                fire = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign moves     = moves_reg;
    assign fsm_state = state;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Self-checking bench for scramble_sequencer (NUM_MOVES=4, GAP_CYCLES=3):
// pass-through vector table, scripted corner sequences and a random soak.
module tb_scramble_sequencer;
    import grid_pkg::*;

    localparam int N = 4;
    localparam int G = 3;

    logic       clk = 1'b0;
    logic       reset, start, abort, user_fire, user_nrow, user_error;
    logic [2:0] rand_bits;
    logic [3:0] user_row_column;
    logic       fire, x_nrow, busy, done;
    logic [3:0] row_column;
    logic [7:0] moves;
    state_t     fsm_state;

    always #5 clk = ~clk;

    scramble_sequencer #(.NUM_MOVES(N), .GAP_CYCLES(G)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .rand_bits       (rand_bits),
        .user_fire       (user_fire),
        .user_row_column (user_row_column),
        .user_nrow       (user_nrow),
        .user_error      (user_error),
        .fire            (fire),
        .row_column      (row_column),
        .x_nrow          (x_nrow),
        .busy            (busy),
        .done            (done),
        .moves           (moves),
        .fsm_state       (fsm_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: scramble position within the fire period (0 = pick, 1 = fire,
    // 2..G+1 = gap), fires issued so far, last accepted move.
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    bit         m_start_q = 1'b0;
    int         m_pos    = 0;
    int         m_moves  = 0;
    logic [4:0] m_move   = 5'd0;

    int          fire_seen = 0;
    int          done_seen = 0;
    bit          track     = 1'b0;
    bit          rand_hold = 1'b0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0] urc;
        logic       un;
        logic       uf;
        logic       ue;
        logic       e_fire;
        logic [3:0] e_rc;
        logic       e_xn;
    } pt_vec_t;

    pt_vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic       e_fire, e_busy, e_done, e_xn, ok, st_edge;
        logic [3:0] e_rc, oh;
        logic [4:0] cand;
        @(negedge clk);
        e_busy = 1'b0;
        e_done = 1'b0;
        e_rc   = m_move[3:0];
        e_xn   = m_move[4];
        e_fire = 1'b0;
        if (!reset || (!m_active && !m_done)) begin
            e_fire = user_fire & ~user_error;
            e_rc   = user_row_column;
            e_xn   = user_nrow;
        end else if (m_done) begin
            e_done = 1'b1;
        end else begin
            e_busy = 1'b1;
            e_fire = (m_pos == 1);
        end
        chk("fire", fire, e_fire);
        chk("row_column", row_column, e_rc);
        chk("x_nrow", x_nrow, e_xn);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("moves", moves, m_moves);
        if (fire && busy) begin
            fire_seen++;
            if (track) begin
                if (exp_q.size() == 0) chk("unexpected_fire", cyc, -1);
                else chk("fire_cycle", cyc, exp_q.pop_front());
            end
        end
        if (done) done_seen++;
        // advance reference with this cycle's inputs
        if (!reset) begin
            m_active = 1'b0; m_done = 1'b0; m_moves = 0; m_move = 5'd0; m_start_q = 1'b0;
        end else begin
            st_edge   = start && !m_start_q;
            m_start_q = start;
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_active) begin
                if (st_edge) begin
                    m_active = 1'b1; m_pos = 0; m_moves = 0;
                end
            end else if (m_pos == 0) begin
                oh   = 4'b0001;
                oh   = oh << rand_bits[1:0];
                cand = {rand_bits[2], oh};
                ok   = 1'b1;
`ifdef SCRAMBLE_NOREPEAT_EN
                ok = (m_moves == 0) || (cand != m_move);
`endif
                if (ok) m_move = cand;
                if (abort) m_active = 1'b0;
                else if (ok) m_pos = 1;
            end else if (m_pos == 1) begin
                if (m_moves < N) m_moves++;
                m_active = !abort;
                m_pos    = 2;
            end else begin
                if (abort) m_active = 1'b0;
                else if (m_pos == G + 1) begin
                    if (m_moves == N) begin
                        m_active = 1'b0; m_done = 1'b1;
                    end else m_pos = 0;
                end else m_pos++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        if (!rand_hold) rand_bits = 3'(cyc);
    endtask

    task automatic push_fires(input int c0, input int count);
        exp_q.delete();
        for (int k = 0; k < count; k++) exp_q.push_back(32'(c0 + 2 + k * (G + 2)));
    endtask

    initial begin
        int c0;
        reset = 1'b0; start = 1'b0; abort = 1'b0; rand_bits = 3'd0;
        user_fire = 1'b0; user_row_column = 4'd0; user_nrow = 1'b0; user_error = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        chk("reset_moves", moves, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b1;
        cycle();

        // IDLE pass-through vectors
        vt[0] = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1};
        vt[1] = '{4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1};
        vt[2] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0};
        vt[3] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0};
        vt[4] = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1};
        vt[5] = '{4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0};
        for (int i = 0; i < 6; i++) begin
            user_row_column = vt[i].urc; user_nrow = vt[i].un;
            user_fire = vt[i].uf; user_error = vt[i].ue;
            #2;
            chk("pt_fire", fire, vt[i].e_fire);
            chk("pt_row_column", row_column, vt[i].e_rc);
            chk("pt_x_nrow", x_nrow, vt[i].e_xn);
            cycle();
        end
        user_fire = 1'b0; user_error = 1'b0; user_row_column = 4'd0; user_nrow = 1'b0;

        // full scramble
        c0 = cyc; push_fires(c0, N); track = 1'b1; fire_seen = 0; done_seen = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (24) cycle();
        track = 1'b0;
        chk("full_fires", fire_seen, N);
        chk("full_exp_left", exp_q.size(), 0);
        chk("full_done_pulses", done_seen, 1);
        chk("full_moves", moves, N);
        chk("full_busy_after", busy, 0);

        // abort in the second gap
        c0 = cyc; push_fires(c0, 2); track = 1'b1; fire_seen = 0; done_seen = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (8) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0; user_fire = 1'b1; user_row_column = 4'b0001;
        #2;
        chk("abort_fire_pass", fire, 1);
        chk("abort_moves", moves, 2);
        chk("abort_busy", busy, 0);
        cycle();
        user_fire = 1'b0;
        repeat (6) cycle();
        track = 1'b0;
        chk("abort_no_done", done_seen, 0);
        chk("abort_fires", fire_seen, 2);

        // reset during the third fire
        c0 = cyc; push_fires(c0, 2); track = 1'b1; fire_seen = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (11) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        #2;
        chk("rst_moves", moves, 0);
        chk("rst_busy", busy, 0);
        repeat (20) cycle();
        track = 1'b0;
        chk("rst_fires", fire_seen, 2);

        // retrigger: start held through DONE, re-pulsed while busy
        c0 = cyc; push_fires(c0, N); track = 1'b1; fire_seen = 0; done_seen = 0;
        start = 1'b1;
        cycle();
        repeat (4) cycle();
        start = 1'b0;
        cycle();
        start = 1'b1;
        repeat (40) cycle();
        track = 1'b0;
        chk("retrig_fires", fire_seen, N);
        chk("retrig_done", done_seen, 1);
        chk("retrig_busy", busy, 0);
        start = 1'b0;
        cycle();

`ifdef SCRAMBLE_NOREPEAT_EN
        // repeated move is resampled until rand changes
        rand_hold = 1'b1; rand_bits = 3'b101;
        c0 = cyc; exp_q.delete();
        exp_q.push_back(32'(c0 + 2)); exp_q.push_back(32'(c0 + 10));
        track = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (8) cycle();
        rand_bits = 3'b010;
        cycle();
        #2;
        chk("norep_fire", fire, 1);
        chk("norep_row_column", row_column, 4'b0100);
        chk("norep_x_nrow", x_nrow, 0);
        cycle();
        track = 1'b0;
        chk("norep_exp_left", exp_q.size(), 0);
        rand_hold = 1'b0;
        repeat (30) cycle();
`endif

        // random soak against the reference
        rand_hold = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) start = ~start;
            abort           = ($urandom_range(0, 59) == 0);
            reset           = ($urandom_range(0, 149) != 0);
            rand_bits       = 3'($urandom_range(0, 7));
            user_fire       = 1'($urandom_range(0, 1));
            user_error      = ($urandom_range(0, 3) == 0);
            user_nrow       = 1'($urandom_range(0, 1));
            user_row_column = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
